mem_port_arbiter: RTL and testbench

- Shares one 32-bit memory/slave port between two masters: m0 = instruction fetch, m1 = data load/store.
- Round-robin arbitration with a registered owner select; the select drives the 2:1 32-bit address/wdata/we muxes into the shared port.
- Sits between the fetch/LSU stages of the multicycle CPU and the unified memory.

---
 rtl/mem_port_arbiter.sv | 85 ++++++++
 tb/tb_mem_port_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one 32-bit memory port between fetch (m0) and LSU (m1); define ARB_TIMEOUT_EN to force error completion on stalled slaves
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic        m0_we,
  input  logic        m1_we,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic [31:0] m_rdata,
  output logic        m_err,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic        s_we,
  input  logic        s_ready,
  input  logic [31:0] s_rdata
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic sel, sel_nx, last_owner, last_nx, done, to_hit, other_req;
  if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_bad_cfg
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  assign to_hit = state == BUSY && !s_ready && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  // stall counter: runs only while the owner waits, cleared by every completion and in idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (state == BUSY && !done) ? cnt + 1'b1 : '0;
`else
  assign to_hit = 1'b0;
`endif
  assign done = state == BUSY && (s_ready || to_hit);
  assign other_req = sel ? m0_req : m1_req;
  // state register; last_owner starts at 1 so m0 wins the first tie
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sel <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      state <= state_nx;
      sel <= sel_nx;
      last_owner <= last_nx;
    end
  // arbitration: grant from idle, or hand straight to the other master on completion
  always_comb begin
    state_nx = state;
    sel_nx = sel;
    last_nx = last_owner;
    if (state == IDLE) begin
      state_nx = (m0_req || m1_req) ? BUSY : IDLE;
      sel_nx = (m0_req && m1_req) ? !last_owner : (m0_req || m1_req) ? m1_req : sel;
    end else if (done) begin
      last_nx = sel;
      state_nx = other_req ? BUSY : IDLE;
      sel_nx = other_req ? !sel : sel;
    end
  end
  // port muxing and completion signalling, all driven from the registered owner
  always_comb begin
    s_valid = state == BUSY;
    m0_gnt = s_valid && !sel;
    m1_gnt = s_valid && sel;
    m0_done = done && !sel;
    m1_done = done && sel;
    m_err = to_hit;
    m_rdata = to_hit ? 32'hDEAD_BEEF : s_rdata;
    s_addr = sel ? m1_addr : m0_addr;
    s_wdata = sel ? m1_wdata : m0_wdata;
    s_we = sel ? m1_we : m0_we;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a behavioural owner/queue model
module tb_mem_port_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0, s_ready = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0, s_rdata = 0;
  logic m0_gnt, m1_gnt, m0_done, m1_done, m_err, s_valid, s_we;
  logic [31:0] m_rdata, s_addr, s_wdata;
  int checks = 0, failures = 0;
  int owner, held, last_o, waitc;
  mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .m0_req(m0_req), .m1_req(m1_req),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_we(m0_we), .m1_we(m1_we), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_done(m0_done), .m1_done(m1_done), .m_rdata(m_rdata), .m_err(m_err),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
    .s_ready(s_ready), .s_rdata(s_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit timeout_now();
`ifdef ARB_TIMEOUT_EN
    return owner >= 0 && !s_ready && waitc == TO - 1;
`else
    return 1'b0;
`endif
  endfunction
  // model: owner -1 = port free; held = master whose inputs drive the port
  always @(posedge clk or negedge rst_n) begin : model
    int w;
    if (!rst_n) begin
      owner <= -1; held <= 0; last_o <= 1; waitc <= 0;
    end else if (owner < 0) begin
      if (m0_req || m1_req) begin
        w = (m0_req && m1_req) ? 1 - last_o : (m1_req ? 1 : 0);
        owner <= w; held <= w; waitc <= 0;
      end
    end else if (s_ready || timeout_now()) begin
      last_o <= owner;
      waitc <= 0;
      if (owner == 0 ? m1_req : m0_req) begin
        owner <= 1 - owner; held <= 1 - owner;
      end else owner <= -1;
    end else waitc <= waitc + 1;
  end
  always @(negedge clk) begin : compare
    logic th, dn;
    logic [6:0] ectl;
    th = timeout_now();
    dn = owner >= 0 && (s_ready || th);
    ectl = {owner >= 0, owner == 0, owner == 1, dn && owner == 0, dn && owner == 1, th,
            held == 1 ? m1_we : m0_we};
    chk("model_ctrl", {25'b0, s_valid, m0_gnt, m1_gnt, m0_done, m1_done, m_err, s_we}, {25'b0, ectl});
    chk("model_s_addr", s_addr, held == 1 ? m1_addr : m0_addr);
    chk("model_s_wdata", s_wdata, held == 1 ? m1_wdata : m0_wdata);
    if (dn) chk("model_rdata", m_rdata, th ? 32'hDEAD_BEEF : s_rdata);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    m0_req = 0; m1_req = 0; s_ready = 0;
    rst_n = 0;
    #2;
    rst_n = 1;
  endtask
  task automatic step_master(inout logic req, inout logic [31:0] addr, inout logic [31:0] wd,
                             inout logic we, input logic dn);
    if (req && !dn) return;
    req = req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
    addr = $urandom; wd = $urandom; we = 1'($urandom_range(0, 1));
  endtask
  initial begin
    logic d0, d1;
    #12 rst_n = 1;
    @(negedge clk);
    chk("reset_ctrl", {26'b0, s_valid, m0_gnt, m1_gnt, m0_done, m1_done, m_err}, 32'h0);
    tick();
    m0_addr = 32'h0040_0000; m0_we = 0; m0_req = 1;
    tick();
    @(negedge clk);
    chk("t1_gnt", {30'b0, m0_gnt, s_valid}, 32'h3);
    chk("t1_addr", s_addr, 32'h0040_0000);
    tick();
    @(negedge clk);
    chk("t1_nodone", {31'b0, m0_done}, 32'h0);
    tick();
    s_ready = 1; s_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("t1_done", {30'b0, m0_done, m_err}, 32'h2);
    chk("t1_rdata", m_rdata, 32'h1234_5678);
    tick();
    do_reset();
    m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200; m0_req = 1; m1_req = 1; s_ready = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("rr_gnt", {30'b0, m0_gnt, m1_gnt}, (k % 2) != 0 ? 32'h1 : 32'h2);
      chk("rr_addr", s_addr, (k % 2) != 0 ? 32'h0000_0200 : 32'h0000_0100);
    end
    tick();
    do_reset();
    m1_addr = 32'h1001_0004; m1_wdata = 32'hCAFE_F00D; m1_we = 1; m1_req = 1;
    m0_addr = $urandom; m0_wdata = $urandom; m0_we = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      m0_addr = $urandom; m0_wdata = $urandom; m0_we = 1'(k);
      @(negedge clk);
      chk("wr_gnt", {31'b0, m1_gnt}, 32'h1);
      chk("wr_we", {31'b0, s_we}, 32'h1);
      chk("wr_wdata", s_wdata, 32'hCAFE_F00D);
      chk("wr_addr", s_addr, 32'h1001_0004);
    end
    tick();
    do_reset();
    m0_req = 1;
    tick();
    tick();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_async", {27'b0, s_valid, m0_gnt, m1_gnt, m0_done, m1_done}, 32'h0);
    m1_req = 1;
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_tie", {30'b0, m0_gnt, m1_gnt}, 32'h2);
    tick();
    do_reset();
    m0_req = 1; m0_addr = 32'h0000_0040; s_ready = 0;
    tick();
    m1_req = 1; m1_addr = 32'h0000_0080;
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      chk("to_done_err", {30'b0, m0_done, m_err}, k == TO ? 32'h3 : 32'h0);
      if (k == TO) chk("to_rdata", m_rdata, 32'hDEAD_BEEF);
    end
    @(negedge clk);
    chk("to_next_gnt", {30'b0, m0_gnt, m1_gnt}, 32'h1);
`else
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      chk("stall_hold", {29'b0, m0_gnt, m_err, m0_done}, 32'h4);
    end
    @(posedge clk);
    #1 s_ready = 1;
    @(negedge clk);
    chk("stall_done", {30'b0, m0_done, m_err}, 32'h2);
    @(negedge clk);
    chk("stall_next_gnt", {30'b0, m0_gnt, m1_gnt}, 32'h1);
`endif
    tick();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      d0 = m0_done; d1 = m1_done;
      tick();
      step_master(m0_req, m0_addr, m0_wdata, m0_we, d0);
      step_master(m1_req, m1_addr, m1_wdata, m1_we, d1);
`ifdef ARB_TIMEOUT_EN
      s_ready = ($urandom_range(0, 3) == 0);
`else
      s_ready = 1'($urandom_range(0, 1));
`endif
      s_rdata = $urandom;
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
